closest_hit_unit: RTL and testbench

//  Consumes the per-triangle result stream of the ray/triangle intersection stage and reduces it
//  to one nearest-hit record per ray. It sits directly downstream of the intersection stage,

---
 rtl/rt_pkg.sv | 41 ++++
 rtl/closest_hit_unit_hit_select.sv | 49 ++++
 rtl/closest_hit_unit.sv | 175 +++++++++++++++++
 tb/tb_closest_hit_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// -----------------------------------------------------------------------------
// rt_pkg
// Shared ray-tracing types and constants.
//   fip32_t   : signed Q16.16 fixed point (32'sh00010000 = 1.0)
//   vec3_t    : packed [0:2] vector of fip32_t
//   hit_rec_t : nearest-hit record {hit, t, normal, tri_id}
//   chu_state_t : closest_hit_unit FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package rt_pkg;

    typedef logic signed [31:0] fip32_t;
    typedef fip32_t [0:2]       vec3_t;

    localparam fip32_t FIP_ONE = 32'sh00010000;
    localparam fip32_t FIP_MAX = 32'sh7FFFFFFF;

    // Width of the triangle index stored inside a hit record.
    localparam int REC_ID_W = 16;

    typedef struct packed {
        logic                hit;
        fip32_t              t;
        vec3_t               normal;
        logic [REC_ID_W-1:0] tri_id;
    } hit_rec_t;

    // Value of the accumulator at the start of every ray: no hit, t at +max.
    localparam hit_rec_t HIT_REC_EMPTY = '{
        hit:    1'b0,
        t:      FIP_MAX,
        normal: '0,
        tri_id: '0
    };

    typedef enum logic [0:0] {
        ST_ACCUM  = 1'b0,
        ST_OUTPUT = 1'b1
    } chu_state_t;

endpackage

// File: rtl/closest_hit_unit_hit_select.sv
// -----------------------------------------------------------------------------
// hit_select
// Combinational compare/select of one intersection beat against the current
// best record of the ray. Produces the record the accumulator should hold if
// the beat is accepted.
// Ports:
//   i_best     in  hit_rec_t   current best record
//   i_result   in  1           triangle reported a hit
//   i_invalid  in  1           intersection arithmetic overflow/div-by-0
//   i_t        in  fip32_t     ray parameter of this triangle
//   i_normal   in  vec3_t      normal of this triangle
//   i_tri_id   in  REC_ID_W    triangle index
//   o_next     out hit_rec_t   candidate next best record
//   o_take     out 1           beat replaces the current best
// -----------------------------------------------------------------------------
module hit_select
    import rt_pkg::*;
(
    input  hit_rec_t            i_best,
    input  logic                i_result,
    input  logic                i_invalid,
    input  fip32_t              i_t,
    input  vec3_t               i_normal,
    input  logic [REC_ID_W-1:0] i_tri_id,
    output hit_rec_t            o_next,
    output logic                o_take
);

    fip32_t w_best_t;
    logic   w_qualify;
    logic   w_closer;

    assign w_best_t  = i_best.t;
    assign w_qualify = i_result & ~i_invalid;
    // Strict less-than: an equal t keeps the earlier triangle.
    assign w_closer  = (i_t < w_best_t);
    assign o_take    = w_qualify & (~i_best.hit | w_closer);

    always_comb begin
        o_next = i_best;
        if (o_take) begin
            o_next.hit    = 1'b1;
            o_next.t      = i_t;
            o_next.normal = i_normal;
            o_next.tri_id = i_tri_id;
        end
    end

endmodule

// File: rtl/closest_hit_unit.sv
// -----------------------------------------------------------------------------
// closest_hit_unit
// Reduces the per-triangle result stream of the intersection stage to one
// nearest-hit record per ray.
//
// Handshake: a beat moves when i_valid & o_ready are both high on a rising
// edge; a record moves when o_valid & i_ready are both high. A sender holds its
// payload stable while valid is high and ready is low.
//
// Optional feature macro: CLOSEST_HIT_STATS_EN adds o_n_tested / o_n_inval
// (saturating per-ray beat counters presented with the record).
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_valid / o_ready   intersection beat handshake
//   i_result, i_invalid hit flag and arithmetic-fault flag of the beat
//   i_t, i_normal       Q16.16 ray parameter and normal of the beat
//   i_tri_id, i_last    triangle index, final triangle of the ray
//   o_valid / i_ready   hit record handshake
//   o_hit, o_t, o_normal, o_tri_id   nearest-hit record
//   o_dbg_state         current FSM state (observation only)
//   o_n_tested, o_n_inval            per-ray counters (stats build only)
// -----------------------------------------------------------------------------
module closest_hit_unit
    import rt_pkg::*;
#(
    parameter int ID_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_result,
    input  logic             i_invalid,
    input  fip32_t           i_t,
    input  vec3_t            i_normal,
    input  logic [ID_W-1:0]  i_tri_id,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_hit,
    output fip32_t           o_t,
    output vec3_t            o_normal,
    output logic [ID_W-1:0]  o_tri_id,
    output chu_state_t       o_dbg_state
`ifdef CLOSEST_HIT_STATS_EN
    ,
    output logic [CNT_W-1:0] o_n_tested,
    output logic [CNT_W-1:0] o_n_inval
`endif
);

    chu_state_t          r_state;
    chu_state_t          w_state_nxt;
    hit_rec_t            r_best;
    hit_rec_t            w_sel_next;
    logic                w_sel_take;
    logic                r_rdy_en;
    logic                w_ready;
    logic                w_valid;
    logic                w_beat;
    logic                w_rec_xfer;
    logic [REC_ID_W-1:0] w_beat_id;

    assign w_beat_id = REC_ID_W'(i_tri_id);

    hit_select u_hit_select (
        .i_best    (r_best),
        .i_result  (i_result),
        .i_invalid (i_invalid),
        .i_t       (i_t),
        .i_normal  (i_normal),
        .i_tri_id  (w_beat_id),
        .o_next    (w_sel_next),
        .o_take    (w_sel_take)
    );

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                w_ready = r_rdy_en;
                if (i_valid && r_rdy_en && i_last) begin
                    w_state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                w_valid = 1'b1;
                if (i_ready) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    assign o_ready    = w_ready;
    assign o_valid    = w_valid;
    assign w_beat     = i_valid & w_ready;
    assign w_rec_xfer = w_valid & i_ready;

    // Keeps o_ready low until the first edge after reset is released.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Best-hit accumulator. It doubles as the output record register, so
    // the record is stable for the whole OUTPUT state by construction.
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_best <= HIT_REC_EMPTY;
        end else if (w_rec_xfer) begin
            r_best <= HIT_REC_EMPTY;
        end else if (w_beat && w_sel_take) begin
            r_best <= w_sel_next;
        end
    end

    assign o_hit       = r_best.hit;
    assign o_t         = r_best.t;
    assign o_normal    = r_best.normal;
    assign o_tri_id    = ID_W'(r_best.tri_id);
    assign o_dbg_state = r_state;

`ifdef CLOSEST_HIT_STATS_EN
    logic [CNT_W-1:0] r_n_tested;
    logic [CNT_W-1:0] r_n_inval;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_n_tested <= '0;
            r_n_inval  <= '0;
        end else if (w_rec_xfer) begin
            r_n_tested <= '0;
            r_n_inval  <= '0;
        end else if (w_beat) begin
            if (r_n_tested != '1) begin
                r_n_tested <= r_n_tested + CNT_W'(1);
            end
            if (i_invalid && (r_n_inval != '1)) begin
                r_n_inval <= r_n_inval + CNT_W'(1);
            end
        end
    end

    assign o_n_tested = r_n_tested;
    assign o_n_inval  = r_n_inval;
`endif

endmodule

// File: tb/tb_closest_hit_unit.sv
// -----------------------------------------------------------------------------
// tb_closest_hit_unit
// Directed bench for closest_hit_unit. Build with +define+CLOSEST_HIT_STATS_EN
// to also exercise the per-ray counters.
// -----------------------------------------------------------------------------
module tb_closest_hit_unit;
    import rt_pkg::*;

    localparam int ID_W  = 16;
    localparam int CNT_W = 16;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             i_valid;
    logic             o_ready;
    logic             i_result;
    logic             i_invalid;
    fip32_t           i_t;
    vec3_t            i_normal;
    logic [ID_W-1:0]  i_tri_id;
    logic             i_last;
    logic             o_valid;
    logic             i_ready;
    logic             o_hit;
    fip32_t           o_t;
    vec3_t            o_normal;
    logic [ID_W-1:0]  o_tri_id;
    chu_state_t       o_dbg_state;
`ifdef CLOSEST_HIT_STATS_EN
    logic [CNT_W-1:0] o_n_tested;
    logic [CNT_W-1:0] o_n_inval;
`endif

    closest_hit_unit #(.ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_result    (i_result),
        .i_invalid   (i_invalid),
        .i_t         (i_t),
        .i_normal    (i_normal),
        .i_tri_id    (i_tri_id),
        .i_last      (i_last),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_hit       (o_hit),
        .o_t         (o_t),
        .o_normal    (o_normal),
        .o_tri_id    (o_tri_id),
        .o_dbg_state (o_dbg_state)
`ifdef CLOSEST_HIT_STATS_EN
        ,
        .o_n_tested  (o_n_tested),
        .o_n_inval   (o_n_inval)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic vec3_t mk_norm(input int n);
        vec3_t v;
        v[0] = fip32_t'(n);
        v[1] = fip32_t'(n * 2);
        v[2] = fip32_t'(-n);
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!o_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!o_ready) check("ready_timeout", {95'd0, o_ready}, 96'd1);
    endtask

    task automatic beat(input logic res, input logic inv, input logic [31:0] t,
                        input int id, input logic last, input int n);
        wait_ready();
        i_valid   = 1'b1;
        i_result  = res;
        i_invalid = inv;
        i_t       = fip32_t'(t);
        i_normal  = mk_norm(n);
        i_tri_id  = ID_W'(id);
        i_last    = last;
        @(posedge clk);
        #1;
        i_valid   = 1'b0;
        i_last    = 1'b0;
    endtask

    task automatic check_record(input string tag, input logic hit, input logic [31:0] t,
                                input vec3_t nrm, input int id);
        check({tag, "_valid"},  {95'd0, o_valid}, 96'd1);
        check({tag, "_ready0"}, {95'd0, o_ready}, 96'd0);
        check({tag, "_hit"},    {95'd0, o_hit}, {95'd0, hit});
        check({tag, "_t"},      {64'd0, o_t}, {64'd0, t});
        check({tag, "_normal"}, o_normal, nrm);
        check({tag, "_id"},     {80'd0, o_tri_id}, {80'd0, ID_W'(id)});
    endtask

    task automatic accept_record(input string tag);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        check({tag, "_valid_drop"}, {95'd0, o_valid}, 96'd0);
        check({tag, "_ready_back"}, {95'd0, o_ready}, 96'd1);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        i_valid   = 1'b0;
        i_result  = 1'b0;
        i_invalid = 1'b0;
        i_t       = '0;
        i_normal  = '0;
        i_tri_id  = '0;
        i_last    = 1'b0;
        i_ready   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",  {95'd0, o_valid}, 96'd0);
        check("rst_hit",    {95'd0, o_hit}, 96'd0);
        check("rst_t",      {64'd0, o_t}, {64'd0, 32'h7FFFFFFF});
        check("rst_normal", o_normal, 96'd0);
        check("rst_id",     {80'd0, o_tri_id}, 96'd0);
        check("rst_state",  {95'd0, o_dbg_state}, {95'd0, ST_ACCUM});
`ifdef CLOSEST_HIT_STATS_EN
        check("rst_n_tested", {80'd0, o_n_tested}, 96'd0);
        check("rst_n_inval",  {80'd0, o_n_inval}, 96'd0);
`endif
        rst = 1'b0;
        check("rdy_before_edge", {95'd0, o_ready}, 96'd0);
        @(posedge clk);
        #1;
        check("rdy_after_edge", {95'd0, o_ready}, 96'd1);

        // 1: nearest of three, with idle gaps that must hold state
        beat(1'b1, 1'b0, 32'h00020000, 5, 1'b0, 1);
        idle(2);
        beat(1'b1, 1'b0, 32'h00010000, 6, 1'b0, 4);
        idle(1);
        check("t1_no_early_valid", {95'd0, o_valid}, 96'd0);
        beat(1'b1, 1'b0, 32'h00030000, 7, 1'b1, 7);
        check_record("t1", 1'b1, 32'h00010000, mk_norm(4), 6);
        check("t1_state", {95'd0, o_dbg_state}, {95'd0, ST_OUTPUT});
        accept_record("t1");
        check("t1_cleared_t", {64'd0, o_t}, {64'd0, 32'h7FFFFFFF});

        // 2: no hits at all
        beat(1'b0, 1'b0, 32'h00001000, 1, 1'b0, 2);
        beat(1'b0, 1'b0, 32'h00002000, 2, 1'b0, 3);
        beat(1'b0, 1'b0, 32'h00003000, 3, 1'b0, 5);
        beat(1'b0, 1'b0, 32'h00004000, 4, 1'b1, 6);
        check_record("t2", 1'b0, 32'h7FFFFFFF, '0, 0);
`ifdef CLOSEST_HIT_STATS_EN
        check("t2_n_tested", {80'd0, o_n_tested}, 96'd4);
        check("t2_n_inval",  {80'd0, o_n_inval}, 96'd0);
`endif
        accept_record("t2");

        // 3: invalid beat with a smaller t must be ignored
        beat(1'b1, 1'b1, 32'h00008000, 1, 1'b0, 9);
        beat(1'b1, 1'b0, 32'h00020000, 2, 1'b1, 10);
        check_record("t3", 1'b1, 32'h00020000, mk_norm(10), 2);
`ifdef CLOSEST_HIT_STATS_EN
        check("t3_n_tested", {80'd0, o_n_tested}, 96'd2);
        check("t3_n_inval",  {80'd0, o_n_inval}, 96'd1);
`endif
        accept_record("t3");
`ifdef CLOSEST_HIT_STATS_EN
        check("t3_n_tested_clr", {80'd0, o_n_tested}, 96'd0);
`endif

        // 4a: tie keeps the earlier triangle
        beat(1'b1, 1'b0, 32'h00010000, 3, 1'b0, 11);
        beat(1'b1, 1'b0, 32'h00010000, 9, 1'b1, 12);
        check_record("t4_tie", 1'b1, 32'h00010000, mk_norm(11), 3);
        accept_record("t4_tie");

        // 4b: single-beat ray with negative t
        beat(1'b1, 1'b0, 32'hFFFF0000, 11, 1'b1, 13);
        check_record("t4_single", 1'b1, 32'hFFFF0000, mk_norm(13), 11);
        accept_record("t4_single");

        // 4c: negative t beats a positive one (signed compare)
        beat(1'b1, 1'b0, 32'h00010000, 10, 1'b0, 14);
        beat(1'b1, 1'b0, 32'hFFFF0000, 11, 1'b1, 15);
        check_record("t4_signed", 1'b1, 32'hFFFF0000, mk_norm(15), 11);
        accept_record("t4_signed");

        // 5: backpressure holds the record and stalls the input
        beat(1'b1, 1'b0, 32'h00018000, 12, 1'b1, 16);
        i_valid   = 1'b1;
        i_result  = 1'b1;
        i_invalid = 1'b0;
        i_t       = 32'sh00040000;
        i_normal  = mk_norm(20);
        i_tri_id  = ID_W'(20);
        i_last    = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("t5_hold_valid", {95'd0, o_valid}, 96'd1);
            check("t5_hold_ready", {95'd0, o_ready}, 96'd0);
            check("t5_hold_t",     {64'd0, o_t}, {64'd0, 32'h00018000});
            check("t5_hold_id",    {80'd0, o_tri_id}, 96'd12);
        end
        accept_record("t5");
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        beat(1'b1, 1'b0, 32'h00050000, 21, 1'b1, 21);
        check_record("t5_next", 1'b1, 32'h00040000, mk_norm(20), 20);
`ifdef CLOSEST_HIT_STATS_EN
        check("t5_n_tested", {80'd0, o_n_tested}, 96'd2);
`endif
        accept_record("t5_next");

        // 6: reset mid-ray discards the partial record
        beat(1'b1, 1'b0, 32'h00001000, 30, 1'b0, 30);
        beat(1'b1, 1'b0, 32'h00002000, 31, 1'b0, 31);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {95'd0, o_valid}, 96'd0);
        check("t6_rst_hit",   {95'd0, o_hit}, 96'd0);
        check("t6_rst_t",     {64'd0, o_t}, {64'd0, 32'h7FFFFFFF});
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("t6_no_record", {95'd0, o_valid}, 96'd0);
        end
        beat(1'b1, 1'b0, 32'h00030000, 40, 1'b0, 40);
        beat(1'b1, 1'b0, 32'h00020000, 41, 1'b1, 41);
        check_record("t6", 1'b1, 32'h00020000, mk_norm(41), 41);
`ifdef CLOSEST_HIT_STATS_EN
        check("t6_n_tested", {80'd0, o_n_tested}, 96'd2);
`endif
        accept_record("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
